line_assembler: RTL

//  Line-editing stage between the UART receiver and the transmitter.
//  - Collects received bytes (rxuart-style strobe/data) into an internal line buffer, applying backspace editing.
//  - On a terminator or when the line is full, replays the line to a txuart-style (stb/busy) sink, followed by CR LF.
//  - Turns the raw echo path into a line-at-a-time, edited echo for the serial test designs.
//

---
 rtl/line_pkg.sv | 21 ++
 rtl/line_assembler_if.sv | 22 ++
 rtl/line_ram.sv | 25 ++
 rtl/line_assembler.sv | 136 +++++++++++++
 4 files changed

// File: rtl/line_pkg.sv
// Shared ASCII constants and FSM state encoding for the line assembler.
package line_pkg;

  localparam logic [7:0] CHR_BS  = 8'h08;
  localparam logic [7:0] CHR_DEL = 8'h7F;
  localparam logic [7:0] CHR_CR  = 8'h0D;
  localparam logic [7:0] CHR_LF  = 8'h0A;

  typedef enum logic [2:0] {
    ST_COLLECT,
    ST_LOAD,
    ST_EMIT,
    ST_EOL_CR,
    ST_EOL_LF
  } state_t;

  function automatic logic is_erase(input logic [7:0] b);
    return (b == CHR_BS) || (b == CHR_DEL);
  endfunction

endpackage

// File: rtl/line_assembler_if.sv
// Receive strobe, transmit stb/busy handshake and status for the line assembler.
interface line_assembler_if #(
  parameter int unsigned LGLEN = 7
);
  logic             i_stb;
  logic [7:0]       i_data;
  logic             o_stb;
  logic [7:0]       o_data;
  logic             i_busy;
  logic             o_drop;
  logic [LGLEN:0]   o_len;

  modport master (
    output i_stb, i_data, i_busy,
    input  o_stb, o_data, o_drop, o_len
  );

  modport slave (
    input  i_stb, i_data, i_busy,
    output o_stb, o_data, o_drop, o_len
  );
endinterface

// File: rtl/line_ram.sv
// Line buffer: one write port, registered read with write-first bypass on address match.
module line_ram #(
  parameter int unsigned LGLEN = 7
) (
  input  logic             clk,
  input  logic             we,
  input  logic [LGLEN-1:0] waddr,
  input  logic [7:0]       wdata,
  input  logic [LGLEN-1:0] raddr,
  output logic [7:0]       rdata
);
  localparam int unsigned DEPTH = 1 << LGLEN;

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Bypass lets a single-byte forced flush see the byte written in the same cycle.
  always_ff @(posedge clk) begin
    if (we && (waddr == raddr)) rdata <= wdata;
    else                        rdata <= mem[raddr];
  end
endmodule

// File: rtl/line_assembler.sv
// Collects received bytes into an edited line and replays it, followed by CR LF,
// to a stb/busy transmitter.
module line_assembler
  import line_pkg::*;
#(
  parameter int unsigned LGLEN  = 7,
  parameter int unsigned MAXLEN = 80
) (
  input  logic             i_clk,
  input  logic             i_reset,
  line_assembler_if.slave  bus
);
  localparam int unsigned CW      = LGLEN + 1;
  localparam logic [CW-1:0] MAX_CNT = CW'(MAXLEN);

  state_t           state;
  logic [CW-1:0]    count;
  logic [LGLEN-1:0] rd;
  logic             cr_seen;
  logic             stb_q;
  logic [7:0]       data_q;
  logic             drop_q;

  logic             accept;
  logic             we;
  logic [LGLEN-1:0] raddr;
  logic [LGLEN-1:0] last_idx;
  logic [7:0]       rdata;
  logic [7:0]       din;

  assign din      = bus.i_data;
  assign accept   = stb_q && !bus.i_busy;
  assign last_idx = LGLEN'(count - CW'(1));
  assign we       = bus.i_stb && (state == ST_COLLECT) && !is_erase(din)
                    && (din != CHR_CR) && (din != CHR_LF);

  // Read one byte ahead of o_data so the next byte is ready on each accept.
  always_comb begin
    raddr = '0;
    case (state)
      ST_LOAD: raddr = LGLEN'(1);
      ST_EMIT: raddr = accept ? (rd + LGLEN'(2)) : (rd + LGLEN'(1));
      default: raddr = '0;
    endcase
  end

  line_ram #(.LGLEN(LGLEN)) u_ram (
    .clk   (i_clk),
    .we    (we),
    .waddr (count[LGLEN-1:0]),
    .wdata (din),
    .raddr (raddr),
    .rdata (rdata)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state   <= ST_COLLECT;
      count   <= '0;
      rd      <= '0;
      cr_seen <= 1'b0;
      stb_q   <= 1'b0;
      data_q  <= '0;
      drop_q  <= 1'b0;
    end else begin
      drop_q <= 1'b0;
      case (state)
        ST_COLLECT: begin
          if (bus.i_stb) begin
            if (is_erase(din)) begin
              if (count != '0) count <= count - CW'(1);
              cr_seen <= 1'b0;
            end else if (din == CHR_CR) begin
              state   <= ST_LOAD;
              cr_seen <= 1'b1;
            end else if (din == CHR_LF) begin
              if (!(cr_seen && (count == '0))) state <= ST_LOAD;
              cr_seen <= 1'b0;
            end else begin
              count   <= count + CW'(1);
              cr_seen <= 1'b0;
              if ((count + CW'(1)) == MAX_CNT) state <= ST_LOAD;
            end
          end
        end
        ST_LOAD: begin
          rd    <= '0;
          stb_q <= 1'b1;
          if (count != '0) begin
            data_q <= rdata;
            state  <= ST_EMIT;
          end else begin
            data_q <= CHR_CR;
            state  <= ST_EOL_CR;
          end
        end
        ST_EMIT: begin
          if (accept) begin
            if (rd == last_idx) begin
              data_q <= CHR_CR;
              state  <= ST_EOL_CR;
            end else begin
              rd     <= rd + LGLEN'(1);
              data_q <= rdata;
            end
          end
        end
        ST_EOL_CR: begin
          if (accept) begin
            data_q <= CHR_LF;
            state  <= ST_EOL_LF;
          end
        end
        ST_EOL_LF: begin
          if (accept) begin
            stb_q <= 1'b0;
            count <= '0;
            state <= ST_COLLECT;
          end
        end
        default: state <= ST_COLLECT;
      endcase

      // Bytes arriving outside COLLECT are lost; the LF of a CRLF pair goes quietly.
      if (bus.i_stb && (state != ST_COLLECT)) begin
        if ((din == CHR_LF) && cr_seen) cr_seen <= 1'b0;
        else                            drop_q  <= 1'b1;
      end
    end
  end

  assign bus.o_stb  = stb_q;
  assign bus.o_data = data_q;
  assign bus.o_drop = drop_q;
  assign bus.o_len  = count;
endmodule
